// File: rtl/peri_bus_arbiter.sv
// peri_bus_arbiter: two-master, one-slave round-robin arbiter for the 32-bit
// peripheral bus. Master 0 is the CPU peripheral port and master 1 is the
// debug loader / DMA. One transaction is in flight at a time. All slave-side
// outputs and master acks are registered.
//
// Optional feature: define PERI_ARB_TIMEOUT_EN to add a slave-response timeout
// of TIMEOUT cycles. A timed-out transaction is acked with err=1 and, for
// reads, rdata=32'hDEADBEEF. Without the macro a transaction can wait forever
// and mN_err is tied to 0.
module peri_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic            m0_ack,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_ack,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,

    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wmask,
    output logic            s_wen,
    output logic            s_ren,
    input  logic            s_wready,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata
);

    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            last_grant, last_grant_n;  // master granted most recently
    logic            owner, owner_n;            // master owning the current transaction
    logic            we_q, we_n;
    logic            skip_q, skip_n;            // write with empty mask: no strobe, ack at once
    logic [AW-1:0]   s_addr_n;
    logic [DW-1:0]   s_wdata_n;
    logic [MW-1:0]   s_wmask_n;
    logic            s_wen_n, s_ren_n;
    logic            m0_ack_n, m1_ack_n;
    logic [DW-1:0]   m0_rdata_n, m1_rdata_n;

    logic            pick;       // master selected in IDLE
    logic            resp;       // response matching the transaction direction
    logic            done;       // transaction completes on the next edge
    logic            timed_out;  // completion caused by the timeout
    logic [DW-1:0]   rd_val;

`ifdef PERI_ARB_TIMEOUT_EN
    logic [15:0]     cnt, cnt_n;
    logic            m0_err_q, m1_err_q, m0_err_n, m1_err_n;
`endif

    // Next-state, next-output and arbitration logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_n      = state;
        last_grant_n = last_grant;
        owner_n      = owner;
        we_n         = we_q;
        skip_n       = skip_q;
        s_addr_n     = s_addr;
        s_wdata_n    = s_wdata;
        s_wmask_n    = s_wmask;
        s_wen_n      = 1'b0;
        s_ren_n      = 1'b0;
        m0_ack_n     = 1'b0;
        m1_ack_n     = 1'b0;
        m0_rdata_n   = m0_rdata;
        m1_rdata_n   = m1_rdata;
        pick         = 1'b0;
        resp         = we_q ? s_wready : s_rvalid;
        done         = 1'b0;
        timed_out    = 1'b0;
        rd_val       = s_rdata;
`ifdef PERI_ARB_TIMEOUT_EN
        cnt_n        = cnt;
        m0_err_n     = 1'b0;
        m1_err_n     = 1'b0;
`endif

        case (state)
            IDLE: begin
                // The ack cycle is spent in IDLE; a request still high there
                // belongs to the transaction just acked and is ignored.
                if (!(m0_ack || m1_ack) && (m0_req || m1_req)) begin
                    pick         = (m0_req && m1_req) ? ~last_grant : m1_req;
                    owner_n      = pick;
                    last_grant_n = pick;
                    we_n         = pick ? m1_we    : m0_we;
                    s_addr_n     = pick ? m1_addr  : m0_addr;
                    s_wdata_n    = pick ? m1_wdata : m0_wdata;
                    s_wmask_n    = pick ? m1_wmask : m0_wmask;
                    skip_n       = we_n && (s_wmask_n == '0);
                    s_wen_n      = we_n && !skip_n;
                    s_ren_n      = !we_n;
                    state_n      = ISSUE;
`ifdef PERI_ARB_TIMEOUT_EN
                    cnt_n        = '0;
`endif
                end
            end

            ISSUE, WAIT: begin
                if (skip_q || resp) begin
                    done = 1'b1;
                end
`ifdef PERI_ARB_TIMEOUT_EN
                else if (cnt + 16'd1 == 16'(TIMEOUT)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
`endif
                if (!done) begin
                    state_n = WAIT;
                end
            end

            default: state_n = IDLE;
        endcase

        if (done) begin
            state_n = IDLE;
            skip_n  = 1'b0;
            rd_val  = timed_out ? DW'(32'hDEADBEEF) : s_rdata;
            if (owner) begin
                m1_ack_n = 1'b1;
                if (!we_q) m1_rdata_n = rd_val;
            end else begin
                m0_ack_n = 1'b1;
                if (!we_q) m0_rdata_n = rd_val;
            end
`ifdef PERI_ARB_TIMEOUT_EN
            m0_err_n = !owner && timed_out;
            m1_err_n =  owner && timed_out;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            skip_q     <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wmask    <= '0;
            s_wen      <= 1'b0;
            s_ren      <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
`ifdef PERI_ARB_TIMEOUT_EN
            cnt        <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            owner      <= owner_n;
            we_q       <= we_n;
            skip_q     <= skip_n;
            s_addr     <= s_addr_n;
            s_wdata    <= s_wdata_n;
            s_wmask    <= s_wmask_n;
            s_wen      <= s_wen_n;
            s_ren      <= s_ren_n;
            m0_ack     <= m0_ack_n;
            m1_ack     <= m1_ack_n;
            m0_rdata   <= m0_rdata_n;
            m1_rdata   <= m1_rdata_n;
`ifdef PERI_ARB_TIMEOUT_EN
            cnt        <= cnt_n;
            m0_err_q   <= m0_err_n;
            m1_err_q   <= m1_err_n;
`endif
        end
    end

`ifdef PERI_ARB_TIMEOUT_EN
    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Testbench for peri_bus_arbiter: directed vector table plus hand-written
// sequences for reset, back-to-back fairness, long waits and the timeout
// (timeout vectors only when PERI_ARB_TIMEOUT_EN is defined).
module tb_peri_bus_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int MW     = 4;
    localparam int TMO    = 8;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [MW-1:0] m0_wmask, m1_wmask;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [MW-1:0] s_wmask;
    logic          s_wen, s_ren, s_wready, s_rvalid;
    logic [DW-1:0] s_rdata;

    int n_checks = 0;
    int n_errors = 0;

    peri_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wen(s_wen),
        .s_ren(s_ren), .s_wready(s_wready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    // Whole-run watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] a0, a1, wd0, wd1;
        logic [3:0]  mk0, mk1;
        int          delay;   // edges after grant before the matching response rises
        logic [31:0] sdata;
        logic        noise;   // drive the non-matching response while waiting
        logic        e_gnt, e_wen, e_ren;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wmask;
        int          e_lat;   // edges from grant edge to ack
        logic        e_err;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic drive_resp(input vec_t v, input int k);
        logic wr, on, nz;
        wr = v.e_gnt ? v.we1 : v.we0;
        on = (k >= v.delay);
        nz = v.noise && !on;
        s_wready = wr ? on : nz;
        s_rvalid = wr ? nz : on;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   k;
        logic got;
        m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.wd0; m0_wmask = v.mk0;
        m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.wd1; m1_wmask = v.mk1;
        s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = v.sdata;
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d_addr", idx),  s_addr,  v.e_addr);
        check($sformatf("v%0d_wdata", idx), s_wdata, v.e_wdata);
        check($sformatf("v%0d_wmask", idx), 32'(s_wmask), 32'(v.e_wmask));
        check($sformatf("v%0d_wen", idx),   32'(s_wen), 32'(v.e_wen));
        check($sformatf("v%0d_ren", idx),   32'(s_ren), 32'(v.e_ren));
        k = 0; got = 1'b0;
        drive_resp(v, k);
        while (!got && k < BUDGET) begin
            @(posedge clk); k++; @(negedge clk);
            if (m0_ack || m1_ack) begin
                got = 1'b1;
            end else begin
                check($sformatf("v%0d_wait_strobe", idx), 32'({s_wen, s_ren}), 32'h0);
                check($sformatf("v%0d_wait_addr", idx), s_addr, v.e_addr);
                drive_resp(v, k);
            end
        end
        check($sformatf("v%0d_ack_seen", idx), 32'(got), 32'h1);
        if (got) begin
            check($sformatf("v%0d_latency", idx), k, v.e_lat);
            check($sformatf("v%0d_m0_ack", idx), 32'(m0_ack), 32'(!v.e_gnt));
            check($sformatf("v%0d_m1_ack", idx), 32'(m1_ack), 32'(v.e_gnt));
            check($sformatf("v%0d_m0_rdata", idx), m0_rdata, v.e_rd0);
            check($sformatf("v%0d_m1_rdata", idx), m1_rdata, v.e_rd1);
            check($sformatf("v%0d_m0_err", idx), 32'(m0_err), 32'(!v.e_gnt && v.e_err));
            check($sformatf("v%0d_m1_err", idx), 32'(m1_err), 32'(v.e_gnt && v.e_err));
        end
        m0_req = 1'b0; m1_req = 1'b0; s_wready = 1'b0; s_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d_ack_pulse", idx), 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
    endtask

    initial begin
        int n_ack, n_strobe, last_ack_edge;
        logic prev_m;

        // ---- table, filled in up front ------------------------------------
        //             r0 r1 we0 we1 a0            a1            wd0           wd1           mk0      mk1      dly  sdata         nz  gnt wen ren e_addr        e_wdata       e_wmask  lat err rd0           rd1
        vecs.push_back('{1, 1, 0, 0, 32'h3000_0008, 32'h4000_0000, 32'h0,        32'h0,        4'hF,    4'hF,    0,   32'h1111_2222, 0,  1,  0,  1,  32'h4000_0000, 32'h0,        4'hF,    1,  0,  32'h41,       32'h1111_2222});
        vecs.push_back('{1, 1, 1, 0, 32'h3000_0010, 32'h4000_0004, 32'h55,       32'h0,        4'hF,    4'hF,    2,   32'hFFFF_FFFF, 1,  0,  1,  0,  32'h3000_0010, 32'h55,       4'hF,    3,  0,  32'h41,       32'h1111_2222});
        vecs.push_back('{0, 1, 0, 1, 32'h0,         32'h4000_0008, 32'h0,        32'hA5,       4'h0,    4'b0001, 5,   32'h0,         1,  1,  1,  0,  32'h4000_0008, 32'hA5,       4'b0001, 6,  0,  32'h41,       32'h1111_2222});
        vecs.push_back('{1, 0, 1, 0, 32'h3000_0020, 32'h0,         32'hDEAD_0000, 32'h0,       4'h0,    4'h0,    99,  32'h0,         0,  0,  0,  0,  32'h3000_0020, 32'hDEAD_0000, 4'h0,   1,  0,  32'h41,       32'h1111_2222});
        vecs.push_back('{1, 0, 0, 0, 32'h3000_0024, 32'h0,         32'h0,        32'h0,        4'hF,    4'h0,    3,   32'hCAFE_F00D, 1,  0,  0,  1,  32'h3000_0024, 32'h0,        4'hF,    4,  0,  32'hCAFE_F00D, 32'h1111_2222});
        vecs.push_back('{1, 1, 0, 0, 32'h3000_0028, 32'h4000_000C, 32'h0,        32'h0,        4'hF,    4'hF,    1,   32'h0BAD_0001, 0,  1,  0,  1,  32'h4000_000C, 32'h0,        4'hF,    2,  0,  32'hCAFE_F00D, 32'h0BAD_0001});
        vecs.push_back('{0, 1, 0, 0, 32'h0,         32'h4000_0010, 32'h0,        32'h0,        4'h0,    4'hF,    0,   32'h1234_5678, 0,  1,  0,  1,  32'h4000_0010, 32'h0,        4'hF,    1,  0,  32'hCAFE_F00D, 32'h1234_5678});
        vecs.push_back('{1, 1, 1, 1, 32'h3000_002C, 32'h4000_0014, 32'h0000_BEEF, 32'h0000_1234, 4'b1100, 4'b0011, 0,  32'h0,         0,  0,  1,  0,  32'h3000_002C, 32'h0000_BEEF, 4'b1100, 1, 0,  32'hCAFE_F00D, 32'h1234_5678});
`ifdef PERI_ARB_TIMEOUT_EN
        vecs.push_back('{1, 0, 0, 0, 32'h3000_0030, 32'h0,         32'h0,        32'h0,        4'hF,    4'h0,    1000, 32'h0,        1,  0,  0,  1,  32'h3000_0030, 32'h0,        4'hF,    TMO, 1, 32'hDEAD_BEEF, 32'h1234_5678});
        vecs.push_back('{0, 1, 0, 0, 32'h0,         32'h4000_0018, 32'h0,        32'h0,        4'h0,    4'hF,    0,   32'h7777_7777, 0,  1,  0,  1,  32'h4000_0018, 32'h0,        4'hF,    1,  0,  32'hDEAD_BEEF, 32'h7777_7777});
`endif

        // ---- reset held 3 cycles with m0 requesting ----------------------
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h3000_0004; m0_wdata = '0; m0_wmask = 4'hF;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("rst_strobes", 32'({s_wen, s_ren}), 32'h0);
            check("rst_s_addr", s_addr, 32'h0);
            check("rst_s_wdata", s_wdata, 32'h0);
            check("rst_s_wmask", 32'(s_wmask), 32'h0);
            check("rst_acks_errs", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
            check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        end
        // Release; slave answers in the ISSUE cycle.
        rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_0041;
        @(posedge clk); @(negedge clk);
        check("first_ren", 32'(s_ren), 32'h1);
        check("first_addr", s_addr, 32'h3000_0004);
        check("first_no_ack", 32'({m0_ack, m1_ack}), 32'h0);
        @(posedge clk); @(negedge clk);
        check("first_m0_ack", 32'(m0_ack), 32'h1);
        check("first_m1_ack", 32'(m1_ack), 32'h0);
        check("first_rdata", m0_rdata, 32'h41);
        check("first_ren_drop", 32'(s_ren), 32'h0);
        m0_req = 1'b0; s_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("first_ack_pulse", 32'(m0_ack), 32'h0);

        // ---- vector table ------------------------------------------------
        foreach (vecs[i]) run_vec(i, vecs[i]);

`ifndef PERI_ARB_TIMEOUT_EN
        // ---- no timeout: a silent slave keeps WAIT for 300 cycles --------
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4000_0020;
        @(posedge clk); @(negedge clk);
        check("long_ren", 32'(s_ren), 32'h1);
        n_ack = 0; n_strobe = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); @(negedge clk);
            if (m0_ack || m1_ack) n_ack++;
            if (s_wen || s_ren) n_strobe++;
        end
        check("long_no_ack", n_ack, 0);
        check("long_no_strobe", n_strobe, 0);
        check("long_addr_held", s_addr, 32'h4000_0020);
        s_rvalid = 1'b1; s_rdata = 32'h5A5A_0001;
        @(posedge clk); @(negedge clk);
        check("long_m1_ack", 32'(m1_ack), 32'h1);
        check("long_m1_rdata", m1_rdata, 32'h5A5A_0001);
        check("long_m1_err", 32'(m1_err), 32'h0);
        m1_req = 1'b0; s_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
`endif

        // ---- both masters requesting continuously, slave always ready -----
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h3000_0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4000_0100;
        s_rvalid = 1'b1; s_rdata = 32'h0000_0099;
        n_ack = 0; prev_m = 1'b1; last_ack_edge = 0;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); @(negedge clk);
            if (m0_ack && m1_ack) check("rr_double_ack", 32'h1, 32'h0);
            if (m0_ack || m1_ack) begin
                // m1 held the last grant, so m0 goes first and they alternate.
                check($sformatf("rr_ack%0d_master", n_ack), 32'(m1_ack), 32'(!prev_m));
                if (n_ack > 0) check($sformatf("rr_ack%0d_gap", n_ack), e - last_ack_edge, 3);
                prev_m = m1_ack;
                last_ack_edge = e;
                n_ack++;
            end
        end
        check("rr_ack_count", n_ack, 5);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); @(negedge clk);
        s_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rr_quiet", 32'({m0_ack, m1_ack, s_wen, s_ren}), 32'h0);

        // ---- reset during ISSUE abandons the transaction -----------------
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h3000_0040;
        @(posedge clk); @(negedge clk);
        check("mid_ren", 32'(s_ren), 32'h1);
        rst = 1'b0; m0_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_ren_drop", 32'(s_ren), 32'h0);
        check("mid_s_addr", s_addr, 32'h0);
        check("mid_rdata", m0_rdata | m1_rdata, 32'h0);
        rst = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            if (m0_ack || m1_ack || s_wen || s_ren) n_ack++;
        end
        check("mid_no_ack", n_ack, 0);
        // last_grant is back to 1, so m0 wins contention again.
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h4000_0040;
        s_rvalid = 1'b1; s_rdata = 32'h0000_0077;
        @(posedge clk); @(negedge clk);
        check("mid_regrant_addr", s_addr, 32'h3000_0040);
        @(posedge clk); @(negedge clk);
        check("mid_regrant_ack", 32'({m0_ack, m1_ack}), 32'b10);
        check("mid_regrant_rdata", m0_rdata, 32'h77);
        m0_req = 1'b0; m1_req = 1'b0; s_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
